// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding,
// access-size encodings, default load latency and the alignment helper
// used when DMEM_MISALIGN_TRAP_EN is defined.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam int LATENCY_DEF = 2;

  // Size 2'b11 is treated as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic mis;
    mis = 1'b0;
    if (size == SZ_H) begin
      mis = lsb[0];
    end else if (size != SZ_B) begin
      mis = (lsb != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Load/store-stage and memory-side signals of the data-memory controller.
// The master modport is the requester/memory environment, the slave modport
// is the controller itself.
interface dmem_if #(
  parameter int ADDR_W = 10
);
  logic              req;
  logic              ren;
  logic [1:0]        size;
  logic [31:0]       daddr;
  logic [31:0]       dwdata;
  logic [3:0]        dwe;
  logic [31:0]       drdata;
  logic              stall;
  logic              done;
  logic              err;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  req, ren, size, daddr, dwdata, dwe, mem_rdata,
    output drdata, stall, done, err, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req, ren, size, daddr, dwdata, dwe, mem_rdata,
    input  drdata, stall, done, err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_wait_cnt.sv
// Load-latency down-counter: loaded on the memory access cycle, counts down
// while enabled and flags zero when the read data is due.
module dmem_wait_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Load has priority over decrement; the counter never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns a held load/store request into a single
// memory access cycle, waits LATENCY cycles for load data, registers it and
// pulses done. Optional feature macro: DMEM_MISALIGN_TRAP_EN (misaligned
// requests complete immediately with err=1 and no memory access).
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = LATENCY_DEF
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_WAIT   = ST_WAIT;
  localparam logic [1:0] S_DONE   = ST_DONE;

  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        dwe_q;
  logic [31:0]       drdata_q;
  logic              accept;
  logic              mis;
  logic              latch;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_zero;
  logic              capture;

  // Address bits above the word index (and size in the default build) are not used.
  logic unused_bits;
  assign unused_bits = ^{bus.daddr[31:ADDR_W+2], bus.size};

  // A request with no byte enables and no load qualifier is ignored.
  assign accept = bus.req && ((bus.dwe != 4'b0000) || bus.ren);

`ifdef DMEM_MISALIGN_TRAP_EN
  assign mis = is_misaligned(bus.size, bus.daddr[1:0]);
`else
  assign mis = 1'b0;
`endif

  // Next-state logic and per-state control strobes.
  always_comb begin
    state_d  = state_q;
    latch    = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          latch   = 1'b1;
          state_d = mis ? S_DONE : S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (dwe_q != 4'b0000) begin
          state_d = S_DONE;
        end else begin
          cnt_load = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_zero) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_en = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch; a load keeps dwe_q at zero, which also marks it as a load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      dwe_q   <= '0;
    end else if (latch) begin
      addr_q  <= bus.daddr[ADDR_W+1:2];
      wdata_q <= bus.dwdata;
      dwe_q   <= bus.dwe;
    end
  end

  // Load data register, only written by a load capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drdata_q <= '0;
    end else if (capture) begin
      drdata_q <= bus.mem_rdata;
    end
  end

  dmem_wait_cnt #(
    .CNT_W (4)
  ) u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (WAIT_LOAD),
    .en_i       (cnt_en),
    .zero_o     (cnt_zero)
  );

`ifdef DMEM_MISALIGN_TRAP_EN
  logic err_q;

  // Misalignment flag of the request currently being completed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (latch) begin
      err_q <= mis;
    end
  end

  assign bus.err = (state_q == S_DONE) && err_q;
`else
  assign bus.err = 1'b0;
`endif

  // Memory strobes decode straight from state so reset drops them at once.
  assign bus.mem_en    = (state_q == S_ACCESS);
  assign bus.mem_we    = (state_q == S_ACCESS) ? dwe_q : 4'b0000;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.drdata    = drdata_q;
  assign bus.done      = (state_q == S_DONE);
  assign bus.stall     = reset && (((state_q == S_IDLE) && accept) ||
                                   (state_q == S_ACCESS) || (state_q == S_WAIT));

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed vector table, reset and
// ignored-request sequences, then randomized accesses against a word-array
// reference model. Honours DMEM_MISALIGN_TRAP_EN if defined.
module tb_dmem_ctrl;

  localparam int LAT = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;

  dmem_if #(.ADDR_W(10)) bus ();

  dmem_ctrl #(.ADDR_W(10), .LATENCY(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'hCAFEF00D : (32'hA5A50000 | 32'(i));
  endfunction

  // Memory environment: data is presented only in the cycle LAT cycles after
  // the access, otherwise a filler pattern, so an early or late capture shows.
  logic [31:0] tmem [64];
  bit          mem_clr = 1'b1;
  int          rd_cnt = 0;
  logic [5:0]  rd_addr = '0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) tmem[i] <= init_word(i);
    end else if (bus.mem_en && (bus.mem_we != 4'b0000)) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) tmem[bus.mem_addr[5:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
    if (bus.mem_en && (bus.mem_we == 4'b0000)) begin
      rd_cnt  <= LAT;
      rd_addr <= bus.mem_addr[5:0];
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
    end
  end

  assign bus.mem_rdata = (rd_cnt == 1) ? tmem[rd_addr] : 32'h5A5A5A5A;

  // Reference model state.
  logic [31:0] ref_mem [64];
  logic [31:0] last_rd = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected outcome of one accepted request, updating the reference memory.
  task automatic model_apply(input logic ren, input logic [3:0] dwe, input logic [1:0] size,
                             input logic [31:0] daddr, input logic [31:0] dwdata,
                             output int lat, output logic err, output int en,
                             output logic [31:0] rd);
    bit mis;
    int w;
    mis = TRAP && (((size == 2'b01) && daddr[0]) || (size[1] && (daddr[1:0] != 2'b00)));
    w = int'(daddr[7:2]);
    if (mis) begin
      lat = 1; err = 1'b1; en = 0; rd = last_rd;
    end else if (dwe != 4'b0000) begin
      for (int b = 0; b < 4; b++)
        if (dwe[b]) ref_mem[w][8*b +: 8] = dwdata[8*b +: 8];
      lat = 2; err = 1'b0; en = 1; rd = last_rd;
    end else begin
      lat = LAT + 2; err = 1'b0; en = 1; rd = ref_mem[w]; last_rd = rd;
    end
    if (ren === 1'bx) lat = -1;
  endtask

  // Drive one request, hold it until done (bounded), and check the outcome.
  task automatic run_txn(input string nm, input logic ren, input logic [3:0] dwe,
                         input logic [1:0] size, input logic [31:0] daddr,
                         input logic [31:0] dwdata, input int exp_lat,
                         input logic exp_err, input int exp_en, input logic [31:0] exp_rd);
    int k, en_cnt, lat;
    bit got, stall_ok;
    logic err_s;
    logic [31:0] rd_s, wd_s;
    logic [9:0] addr_s;
    logic [3:0] we_s;
    @(negedge clk);
    bus.req = 1'b1; bus.ren = ren; bus.dwe = dwe; bus.size = size;
    bus.daddr = daddr; bus.dwdata = dwdata;
    #1;
    stall_ok = (bus.stall === 1'b1) && (bus.mem_en === 1'b0);
    k = 0; en_cnt = 0; got = 0; lat = -1;
    err_s = 1'b0; rd_s = '0; wd_s = '0; addr_s = '0; we_s = '0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.mem_en === 1'b1) begin
        en_cnt++; addr_s = bus.mem_addr; we_s = bus.mem_we; wd_s = bus.mem_wdata;
      end
      if (bus.done === 1'b1) begin
        got = 1; lat = k; err_s = bus.err; rd_s = bus.drdata;
        if (bus.stall !== 1'b0) stall_ok = 0;
      end else if (bus.stall !== 1'b1) begin
        stall_ok = 0;
      end
    end
    bus.req = 1'b0; bus.ren = 1'b0; bus.dwe = 4'b0000;
    check({nm, " latency"}, 32'(lat), 32'(exp_lat));
    check({nm, " err"}, 32'(err_s), 32'(exp_err));
    check({nm, " drdata"}, rd_s, exp_rd);
    check({nm, " mem_en pulses"}, 32'(en_cnt), 32'(exp_en));
    check({nm, " stall shape"}, 32'(stall_ok), 32'd1);
    if (exp_en == 1) begin
      check({nm, " mem_addr"}, 32'(addr_s), 32'(daddr[11:2]));
      check({nm, " mem_we"}, 32'(we_s), 32'(dwe));
      check({nm, " mem_wdata"}, wd_s, dwdata);
    end
  endtask

  typedef struct {
    logic        ren;
    logic [3:0]  dwe;
    logic [1:0]  size;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    int          lat;
    logic        err;
    int          en;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [13];

  initial begin
    int lat, en, bad, dn;
    logic err;
    logic [31:0] rd;
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, en, bad, dn;
    logic err;
    logic [31:0] rd;
    logic r;
    logic [3:0] we;
    logic [1:0] sz;
    logic [31:0] a, d;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    bus.req = 1'b0; bus.ren = 1'b0; bus.dwe = 4'b0000; bus.size = 2'b10;
    bus.daddr = '0; bus.dwdata = '0;

    // Vector table: hand-derived expectations.
    tbl[0]  = '{1'b1, 4'b0000, 2'b10, 32'h10, 32'h0,        LAT+2, 1'b0, 1, 32'hCAFEF00D};
    tbl[1]  = '{1'b0, 4'b0011, 2'b10, 32'h10, 32'h0000BEEF, 2,     1'b0, 1, 32'hCAFEF00D};
    tbl[2]  = '{1'b1, 4'b0000, 2'b10, 32'h10, 32'h0,        LAT+2, 1'b0, 1, 32'hCAFEBEEF};
    tbl[3]  = '{1'b0, 4'b1100, 2'b10, 32'h20, 32'h12340000, 2,     1'b0, 1, 32'hCAFEBEEF};
    tbl[4]  = '{1'b1, 4'b0000, 2'b10, 32'h20, 32'h0,        LAT+2, 1'b0, 1, 32'h12340008};
    tbl[5]  = '{1'b1, 4'b1111, 2'b10, 32'h24, 32'h89ABCDEF, 2,     1'b0, 1, 32'h12340008};
    tbl[6]  = '{1'b1, 4'b0000, 2'b10, 32'h24, 32'h0,        LAT+2, 1'b0, 1, 32'h89ABCDEF};
    tbl[9]  = '{1'b1, 4'b0000, 2'b00, 32'h13, 32'h0,        LAT+2, 1'b0, 1, 32'hCAFEBEEF};
`ifdef DMEM_MISALIGN_TRAP_EN
    tbl[7]  = '{1'b1, 4'b0000, 2'b10, 32'h12, 32'h0,        1,     1'b1, 0, 32'h89ABCDEF};
    tbl[8]  = '{1'b1, 4'b0000, 2'b01, 32'h13, 32'h0,        1,     1'b1, 0, 32'h89ABCDEF};
    tbl[10] = '{1'b0, 4'b0011, 2'b01, 32'h21, 32'h00005555, 1,     1'b1, 0, 32'hCAFEBEEF};
    tbl[11] = '{1'b1, 4'b0000, 2'b10, 32'h20, 32'h0,        LAT+2, 1'b0, 1, 32'h12340008};
    tbl[12] = '{1'b1, 4'b0000, 2'b11, 32'h22, 32'h0,        1,     1'b1, 0, 32'h12340008};
`else
    tbl[7]  = '{1'b1, 4'b0000, 2'b10, 32'h12, 32'h0,        LAT+2, 1'b0, 1, 32'hCAFEBEEF};
    tbl[8]  = '{1'b1, 4'b0000, 2'b01, 32'h13, 32'h0,        LAT+2, 1'b0, 1, 32'hCAFEBEEF};
    tbl[10] = '{1'b0, 4'b0011, 2'b01, 32'h21, 32'h00005555, 2,     1'b0, 1, 32'hCAFEBEEF};
    tbl[11] = '{1'b1, 4'b0000, 2'b10, 32'h20, 32'h0,        LAT+2, 1'b0, 1, 32'h12345555};
    tbl[12] = '{1'b1, 4'b0000, 2'b11, 32'h22, 32'h0,        LAT+2, 1'b0, 1, 32'h12345555};
`endif

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset stall", 32'(bus.stall), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset err", 32'(bus.err), 32'd0);
    check("reset mem_en", 32'(bus.mem_en), 32'd0);
    check("reset mem_we", 32'(bus.mem_we), 32'd0);
    check("reset mem_addr", 32'(bus.mem_addr), 32'd0);
    check("reset mem_wdata", bus.mem_wdata, 32'd0);
    check("reset drdata", bus.drdata, 32'd0);
    reset = 1'b1;
    mem_clr = 1'b0;

    for (int i = 0; i < 13; i++) begin
      run_txn($sformatf("vec%0d", i), tbl[i].ren, tbl[i].dwe, tbl[i].size, tbl[i].daddr,
              tbl[i].dwdata, tbl[i].lat, tbl[i].err, tbl[i].en, tbl[i].rd);
      model_apply(tbl[i].ren, tbl[i].dwe, tbl[i].size, tbl[i].daddr, tbl[i].dwdata,
                  lat, err, en, rd);
    end

    // Ignored request: no enables and no load qualifier for 5 cycles.
    @(negedge clk);
    bus.req = 1'b1; bus.ren = 1'b0; bus.dwe = 4'b0000; bus.daddr = 32'h30;
    bad = 0; dn = 0;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (bus.stall !== 1'b0 || bus.mem_en !== 1'b0) bad++;
      if (bus.done !== 1'b0) dn++;
      @(negedge clk);
    end
    bus.req = 1'b0;
    check("ignored req stall/mem_en", 32'(bad), 32'd0);
    check("ignored req done", 32'(dn), 32'd0);
    model_apply(1'b1, 4'b0000, 2'b10, 32'h24, 32'h0, lat, err, en, rd);
    run_txn("after ignored", 1'b1, 4'b0000, 2'b10, 32'h24, 32'h0, lat, err, en, rd);

    // Reset during WAIT: no completion, drdata cleared.
    @(negedge clk);
    bus.req = 1'b1; bus.ren = 1'b1; bus.dwe = 4'b0000; bus.size = 2'b10; bus.daddr = 32'h10;
    repeat (2) @(negedge clk);
    check("pre-reset drdata nonzero", 32'(bus.drdata != 32'd0), 32'd1);
    reset = 1'b0;
    #1;
    check("wait-reset drdata", bus.drdata, 32'd0);
    check("wait-reset stall", 32'(bus.stall), 32'd0);
    check("wait-reset mem_en", 32'(bus.mem_en), 32'd0);
    bus.req = 1'b0; bus.ren = 1'b0;
    @(negedge clk);
    check("wait-reset done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    last_rd = '0;
    model_apply(1'b0, 4'b1111, 2'b10, 32'h28, 32'h0BADF00D, lat, err, en, rd);
    run_txn("store after reset", 1'b0, 4'b1111, 2'b10, 32'h28, 32'h0BADF00D, lat, err, en, rd);

    // Reset during ACCESS: write strobe drops at once, store never lands.
    @(negedge clk);
    bus.req = 1'b1; bus.ren = 1'b0; bus.dwe = 4'b1111; bus.daddr = 32'h30; bus.dwdata = 32'hFFFF0000;
    @(negedge clk);
    check("access mem_we before reset", 32'(bus.mem_we), 32'hF);
    reset = 1'b0;
    #1;
    check("access-reset mem_we", 32'(bus.mem_we), 32'd0);
    check("access-reset mem_en", 32'(bus.mem_en), 32'd0);
    check("access-reset stall", 32'(bus.stall), 32'd0);
    bus.req = 1'b0; bus.dwe = 4'b0000;
    @(negedge clk);
    check("access-reset done", 32'(bus.done), 32'd0);
    reset = 1'b1;
    last_rd = '0;
    model_apply(1'b1, 4'b0000, 2'b10, 32'h30, 32'h0, lat, err, en, rd);
    run_txn("load after access-reset", 1'b1, 4'b0000, 2'b10, 32'h30, 32'h0, lat, err, en, rd);

    // Randomized accesses against the reference model.
    for (int n = 0; n < 80; n++) begin
      r  = 1'($urandom_range(0, 1));
      we = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      if (we == 4'b0000) r = 1'b1;
      sz = 2'($urandom_range(0, 3));
      a  = {24'd0, 6'($urandom_range(0, 63)), 2'($urandom_range(0, 3))};
      d  = $urandom;
      model_apply(r, we, sz, a, d, lat, err, en, rd);
      run_txn($sformatf("rnd%0d", n), r, we, sz, a, d, lat, err, en, rd);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
